// File: rtl/io_out_seq.sv
// io_out_seq: output digit sequencer on the I/O side of the arithmetic unit.
// It orders one 3- or 4-bit left shift of register C per digit and collects the
// bits leaving the C sign position, MSB first. Each assembled digit goes to the
// output device through a valid/ready handshake. When the operation ends, or
// fails, it reports to the operation control with a done pulse and a sticky
// error flag.
module io_out_seq #(
  parameter int TIMEOUT    = 15,
  parameter int MAX_DIGITS = 10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start_from_op,
  input  logic [3:0] digit_count_from_op,
  input  logic       mode_4bit_from_op,
  input  logic       abort_from_pu,
  output logic       order_io_to_ac,
  output logic       shift_3_bit_to_ac,
  output logic       shift_4_bit_to_ac,
  input  logic       do_left_shift_c_from_ac,
  input  logic       output_sign_from_ac,
  input  logic       ac_answer_from_ac,
  output logic [3:0] digit_to_dev,
  output logic       digit_valid_to_dev,
  input  logic       dev_ready_from_dev,
  output logic       busy_to_op,
  output logic       done_to_op,
  output logic       error_to_op
);

  localparam int              TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMEOUT_V = TW'(TIMEOUT);
  localparam logic [3:0]      MAX_V     = 4'(MAX_DIGITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ORDER,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            mode;
  logic [3:0]      sr;
  logic [2:0]      bitcnt;
  logic [TW-1:0]   timer;
  logic            error_q;
  logic [3:0]      digit_q;

  logic [3:0]      sr_shift;
  logic [2:0]      bitcnt_shift;
  logic [TW-1:0]   timer_inc;
  logic [2:0]      bits_needed;
  logic            count_ok;

  // Shift register and bit counter as they will be after this edge's shift,
  // so a shift and an answer in the same cycle compare the updated count.
  always_comb begin
    // NOTE: every combinational output gets a default first, otherwise paths
    // that skip an assignment infer a latch.
    sr_shift     = sr;
    bitcnt_shift = bitcnt;
    if (do_left_shift_c_from_ac) begin
      sr_shift = {sr[2:0], output_sign_from_ac};
      if (bitcnt != 3'd7) bitcnt_shift = bitcnt + 3'd1;
    end
  end

  assign timer_inc   = timer + TW'(1);
  assign bits_needed = mode ? 3'd4 : 3'd3;
  assign count_ok    = (digit_count_from_op != 4'd0) && (digit_count_from_op <= MAX_V);

  // Sequencer: the single FSM with its per-operation and per-digit registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      state   <= S_IDLE;
      cnt     <= 4'd0;
      mode    <= 1'b0;
      sr      <= 4'd0;
      bitcnt  <= 3'd0;
      timer   <= '0;
      error_q <= 1'b0;
      digit_q <= 4'd0;
    end else if (abort_from_pu) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_from_op) begin
            if (count_ok) begin
              cnt     <= digit_count_from_op;
              mode    <= mode_4bit_from_op;
              error_q <= 1'b0;
              state   <= S_ORDER;
            end else begin
              error_q <= 1'b1;
              state   <= S_DONE;
            end
          end
        end
        S_ORDER: begin
          sr     <= 4'd0;
          bitcnt <= 3'd0;
          timer  <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          sr     <= sr_shift;
          bitcnt <= bitcnt_shift;
          timer  <= timer_inc;
          if (ac_answer_from_ac) begin
            if (bitcnt_shift == bits_needed) begin
              digit_q <= mode ? sr_shift : {1'b0, sr_shift[2:0]};
              state   <= S_PRESENT;
            end else begin
              error_q <= 1'b1;
              state   <= S_DONE;
            end
          end else if (timer_inc == TIMEOUT_V) begin
            error_q <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_PRESENT: begin
          if (dev_ready_from_dev) begin
            if (cnt == 4'd1) begin
              state <= S_DONE;
            end else begin
              cnt   <= cnt - 4'd1;
              state <= S_ORDER;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decoded from the state register and held registers only.
  assign order_io_to_ac     = (state == S_ORDER);
  assign shift_3_bit_to_ac  = ((state == S_ORDER) || (state == S_WAIT)) && !mode;
  assign shift_4_bit_to_ac  = ((state == S_ORDER) || (state == S_WAIT)) && mode;
  assign digit_valid_to_dev = (state == S_PRESENT);
  assign digit_to_dev       = digit_q;
  assign busy_to_op         = (state != S_IDLE);
  assign done_to_op         = (state == S_DONE);
  assign error_to_op        = error_q;

endmodule

// File: tb/tb_io_out_seq.sv
// Directed bench for io_out_seq. Inputs change 1 ns after each rising edge and
// outputs are sampled right after, so "cycle n" means the interval following
// edge n-1, with the start pulse driven in cycle 0.
module tb_io_out_seq;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start_from_op;
  logic [3:0] digit_count_from_op;
  logic       mode_4bit_from_op;
  logic       abort_from_pu;
  logic       order_io_to_ac;
  logic       shift_3_bit_to_ac;
  logic       shift_4_bit_to_ac;
  logic       do_left_shift_c_from_ac;
  logic       output_sign_from_ac;
  logic       ac_answer_from_ac;
  logic [3:0] digit_to_dev;
  logic       digit_valid_to_dev;
  logic       dev_ready_from_dev;
  logic       busy_to_op;
  logic       done_to_op;
  logic       error_to_op;

  int n_checks = 0;
  int n_fail   = 0;
  int order_cnt = 0;
  int done_cnt  = 0;
  int valid_cnt = 0;

  // {order, shift3, shift4, valid, busy, done, error}
  logic [6:0] ctl;
  assign ctl = {order_io_to_ac, shift_3_bit_to_ac, shift_4_bit_to_ac,
                digit_valid_to_dev, busy_to_op, done_to_op, error_to_op};

  io_out_seq #(.TIMEOUT(15), .MAX_DIGITS(10)) dut (
    .clk                     (clk),
    .resetn                  (resetn),
    .start_from_op           (start_from_op),
    .digit_count_from_op     (digit_count_from_op),
    .mode_4bit_from_op       (mode_4bit_from_op),
    .abort_from_pu           (abort_from_pu),
    .order_io_to_ac          (order_io_to_ac),
    .shift_3_bit_to_ac       (shift_3_bit_to_ac),
    .shift_4_bit_to_ac       (shift_4_bit_to_ac),
    .do_left_shift_c_from_ac (do_left_shift_c_from_ac),
    .output_sign_from_ac     (output_sign_from_ac),
    .ac_answer_from_ac       (ac_answer_from_ac),
    .digit_to_dev            (digit_to_dev),
    .digit_valid_to_dev      (digit_valid_to_dev),
    .dev_ready_from_dev      (dev_ready_from_dev),
    .busy_to_op              (busy_to_op),
    .done_to_op              (done_to_op),
    .error_to_op             (error_to_op)
  );

  always #5 clk = ~clk;

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (order_io_to_ac)     order_cnt++;
    if (done_to_op)         done_cnt++;
    if (digit_valid_to_dev) valid_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_from_op           = 1'b0;
    digit_count_from_op     = 4'd0;
    mode_4bit_from_op       = 1'b0;
    abort_from_pu           = 1'b0;
    do_left_shift_c_from_ac = 1'b0;
    output_sign_from_ac     = 1'b0;
    ac_answer_from_ac       = 1'b0;
    dev_ready_from_dev      = 1'b0;
  endtask

  // Drive a start pulse for one cycle; returns in cycle 1.
  task automatic do_start(input logic [3:0] count, input logic m4);
    start_from_op       = 1'b1;
    digit_count_from_op = count;
    mode_4bit_from_op   = m4;
    tick();
    start_from_op       = 1'b0;
    digit_count_from_op = 4'd0;
  endtask

  // Called in the first WAIT cycle: n shift pulses MSB first, then the answer.
  // Returns in the cycle after the answer.
  task automatic shift_digit(input logic [3:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      do_left_shift_c_from_ac = 1'b1;
      output_sign_from_ac     = bits[i];
      tick();
    end
    do_left_shift_c_from_ac = 1'b0;
    output_sign_from_ac     = 1'b0;
    ac_answer_from_ac       = 1'b1;
    tick();
    ac_answer_from_ac       = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    #3;
    n_checks++;
    if ({ctl, digit_to_dev} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ctl=%b digit=%h, want 0000000 / 0", ctl, digit_to_dev);
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  // One 3-bit digit, count 1, ready high. A start while busy must be ignored.
  task automatic test_digit3(input logic [2:0] bits, input logic [3:0] exp);
    int d0;
    d0 = done_cnt;
    do_start(4'd1, 1'b0);
    n_checks++;
    if (ctl !== 7'b1100100) begin
      n_fail++;
      $display("FAIL d3_order: got %b want 1100100", ctl);
    end
    tick();
    n_checks++;
    if (ctl !== 7'b0100100) begin
      n_fail++;
      $display("FAIL d3_wait: got %b want 0100100", ctl);
    end
    dev_ready_from_dev      = 1'b1;
    do_left_shift_c_from_ac = 1'b1;
    output_sign_from_ac     = bits[2];
    tick();
    start_from_op       = 1'b1;  // busy: ignored
    digit_count_from_op = 4'd0;
    output_sign_from_ac = bits[1];
    tick();
    start_from_op       = 1'b0;
    output_sign_from_ac = bits[0];
    tick();
    do_left_shift_c_from_ac = 1'b0;
    ac_answer_from_ac       = 1'b1;
    tick();
    ac_answer_from_ac = 1'b0;
    n_checks++;
    if (ctl !== 7'b0001100 || digit_to_dev !== exp) begin
      n_fail++;
      $display("FAIL d3_present: got %b digit %h want 0001100 digit %h", ctl, digit_to_dev, exp);
    end
    tick();
    dev_ready_from_dev = 1'b0;
    n_checks++;
    if (ctl !== 7'b0000110) begin
      n_fail++;
      $display("FAIL d3_done: got %b want 0000110", ctl);
    end
    tick();
    n_checks++;
    if (ctl !== 7'b0000000 || done_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL d3_idle: got %b dones %0d want 0000000 dones %0d", ctl, done_cnt - d0, 1);
    end
  endtask

  task automatic test_back_to_back();
    int o0, d0;
    o0 = order_cnt;
    d0 = done_cnt;
    do_start(4'd2, 1'b1);
    n_checks++;
    if (ctl !== 7'b1010100) begin
      n_fail++;
      $display("FAIL b2b_order: got %b want 1010100", ctl);
    end
    tick();
    shift_digit(4'b1011, 4);
    for (int i = 0; i < 5; i++) begin
      do_left_shift_c_from_ac = 1'b1;  // not in WAIT: ignored
      output_sign_from_ac     = 1'b0;
      n_checks++;
      if (ctl !== 7'b0001100 || digit_to_dev !== 4'hB) begin
        n_fail++;
        $display("FAIL b2b_hold%0d: got %b digit %h want 0001100 digit b", i, ctl, digit_to_dev);
      end
      tick();
    end
    do_left_shift_c_from_ac = 1'b0;
    dev_ready_from_dev      = 1'b1;
    n_checks++;
    if (digit_to_dev !== 4'hB || digit_valid_to_dev !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: got valid %b digit %h want 1 b", digit_valid_to_dev, digit_to_dev);
    end
    tick();
    dev_ready_from_dev = 1'b0;
    n_checks++;
    if (ctl !== 7'b1010100) begin
      n_fail++;
      $display("FAIL b2b_order2: got %b want 1010100", ctl);
    end
    tick();
    shift_digit(4'b0110, 4);
    dev_ready_from_dev = 1'b1;
    n_checks++;
    if (ctl !== 7'b0001100 || digit_to_dev !== 4'h6) begin
      n_fail++;
      $display("FAIL b2b_digit2: got %b digit %h want 0001100 digit 6", ctl, digit_to_dev);
    end
    tick();
    dev_ready_from_dev = 1'b0;
    n_checks++;
    if (ctl !== 7'b0000110) begin
      n_fail++;
      $display("FAIL b2b_done: got %b want 0000110", ctl);
    end
    tick();
    n_checks++;
    if (order_cnt - o0 != 2 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL b2b_counts: got orders %0d dones %0d want 2 1", order_cnt - o0, done_cnt - d0);
    end
  endtask

  task automatic test_timeout();
    int v0;
    v0 = valid_cnt;
    do_start(4'd1, 1'b0);
    tick();  // cycle 2: first WAIT cycle
    for (int c = 2; c < 16; c++) tick();
    n_checks++;
    if (ctl !== 7'b0100100) begin
      n_fail++;
      $display("FAIL to_wait16: got %b want 0100100", ctl);
    end
    tick();  // cycle 17
    n_checks++;
    if (ctl !== 7'b0000111) begin
      n_fail++;
      $display("FAIL to_done: got %b want 0000111", ctl);
    end
    tick();
    n_checks++;
    if (ctl !== 7'b0000001 || valid_cnt != v0) begin
      n_fail++;
      $display("FAIL to_idle: got %b valids %0d want 0000001 valids 0", ctl, valid_cnt - v0);
    end
  endtask

  task automatic test_short_digit();
    int v0;
    v0 = valid_cnt;
    do_start(4'd1, 1'b1);
    tick();
    shift_digit(4'b0101, 3);
    n_checks++;
    if (ctl !== 7'b0000111) begin
      n_fail++;
      $display("FAIL short_done: got %b want 0000111", ctl);
    end
    tick();
    n_checks++;
    if (ctl !== 7'b0000001 || valid_cnt != v0) begin
      n_fail++;
      $display("FAIL short_idle: got %b valids %0d want 0000001 valids 0", ctl, valid_cnt - v0);
    end
    do_start(4'd1, 1'b0);
    n_checks++;
    if (ctl !== 7'b1100100) begin
      n_fail++;
      $display("FAIL short_restart: got %b want 1100100 (error cleared)", ctl);
    end
    abort_from_pu = 1'b1;
    tick();
    abort_from_pu = 1'b0;
    n_checks++;
    if (ctl !== 7'b0000000) begin
      n_fail++;
      $display("FAIL abort_order: got %b want 0000000", ctl);
    end
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    do_start(4'd1, 1'b0);
    tick();
    do_left_shift_c_from_ac = 1'b1;
    output_sign_from_ac     = 1'b1;
    tick();
    tick();
    do_left_shift_c_from_ac = 1'b0;
    abort_from_pu           = 1'b1;
    ac_answer_from_ac       = 1'b1;  // abort wins
    tick();
    abort_from_pu     = 1'b0;
    ac_answer_from_ac = 1'b0;
    n_checks++;
    if (ctl !== 7'b0000000) begin
      n_fail++;
      $display("FAIL abort_wait: got %b want 0000000", ctl);
    end
    tick();
    n_checks++;
    if (done_cnt != d0) begin
      n_fail++;
      $display("FAIL abort_nodone: got %0d done pulses want 0", done_cnt - d0);
    end
    test_digit3(3'b110, 4'h6);
  endtask

  task automatic test_bad_count();
    logic [3:0] bad [2];
    int o0;
    bad[0] = 4'd0;
    bad[1] = 4'd11;
    o0 = order_cnt;
    for (int i = 0; i < 2; i++) begin
      do_start(bad[i], 1'b0);
      n_checks++;
      if (ctl !== 7'b0000111) begin
        n_fail++;
        $display("FAIL badcnt%0d_done: got %b want 0000111", bad[i], ctl);
      end
      tick();
      n_checks++;
      if (ctl !== 7'b0000001) begin
        n_fail++;
        $display("FAIL badcnt%0d_idle: got %b want 0000001", bad[i], ctl);
      end
    end
    n_checks++;
    if (order_cnt != o0) begin
      n_fail++;
      $display("FAIL badcnt_orders: got %0d want 0", order_cnt - o0);
    end
    do_start(4'd10, 1'b1);  // largest legal count
    n_checks++;
    if (ctl !== 7'b1010100) begin
      n_fail++;
      $display("FAIL maxcnt_order: got %b want 1010100", ctl);
    end
    tick();
  endtask

  // Asynchronous reset while in WAIT with no clock edge in between.
  task automatic test_async_reset();
    int d0;
    d0 = done_cnt;
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (ctl !== 7'b0000000 || digit_to_dev !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %b digit %h want 0000000 digit 0", ctl, digit_to_dev);
    end
    tick();
    resetn = 1'b1;
    tick();
    n_checks++;
    if (done_cnt != d0 || ctl !== 7'b0000000) begin
      n_fail++;
      $display("FAIL async_after: got %b dones %0d want 0000000 dones 0", ctl, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_digit3(3'b101, 4'h5);
    test_back_to_back();
    test_timeout();
    test_short_digit();
    test_abort();
    test_bad_count();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
